mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 48 ++++
 rtl/mem_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if -- data-memory request bus between the M pipeline stage and
// the data memory.
//
// Handshake: the stage raises dm_req and holds dm_we/dm_addr/dm_wdata stable
// for as long as dm_req stays high; the memory completes the access by
// pulsing dm_ack for exactly one cycle, and dm_rdata is meaningful only in
// that cycle. An access completes in the cycle dm_ack is seen. dm_ack seen
// while dm_req is low carries no meaning and is ignored by the stage.
//
// Signals:
//   dm_req    stage -> mem   access request (level, held until dm_ack)
//   dm_we     stage -> mem   request is a write
//   dm_addr   stage -> mem   32-bit byte address
//   dm_wdata  stage -> mem   32-bit store data
//   dm_ack    mem -> stage   single-cycle access-complete strobe
//   dm_rdata  mem -> stage   32-bit load data, valid with dm_ack
//
// Modports:
//   master  the pipeline stage issuing accesses
//   slave   the data memory answering them
// ---------------------------------------------------------------------------
interface mem_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- M stage of a five-stage pipeline with a variable-latency data
// memory, plus the M/W pipeline register.
//
// The stage issues a load or store combinationally from the E/M register
// outputs. If the memory does not acknowledge in the same cycle the stage
// raises stallM, freezing everything upstream, and keeps requesting until
// dm_ack arrives. A wait counter bounds the stall: after TIMEOUT WAIT cycles
// without dm_ack the stage enters a sticky fault state (dm_err) that only
// rst leaves. Branch resolution (pcsrcM/pcbranchF) is also produced here.
//
// Parameters:
//   TIMEOUT  maximum WAIT cycles before a fault, 1 .. 2**CNTW-1
//   CNTW     wait-counter width in bits
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   rfweM, mtorfselM, dmweM  M-stage register-write, load-select, store
//   branchM, zeroM           M-stage branch and ALU-zero flags
//   aluoutM                  ALU result / memory address
//   dmdinM                   store data
//   pcbranchM                branch target
//   rtdM                     destination register number
//   dm                       data-memory bus (master side)
//   stallM                   freeze F, D, E stages and the E/M register
//   pcsrcM                   branch taken
//   pcbranchF                branch target forwarded to fetch
//   dm_err                   sticky memory-timeout fault
//   rfweW, mtorfselW         registered W-stage control bits
//   aluoutW, dmoutW          registered W-stage ALU result and load data
//   rtdW                     registered W-stage destination register
//   dbgState                 current FSM state (IDLE=0, WAIT=1, ERR=2)
//   dbgWaitCnt               current wait-counter value
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            rfweM,
    input  logic            mtorfselM,
    input  logic            dmweM,
    input  logic            branchM,
    input  logic            zeroM,
    input  logic [31:0]     aluoutM,
    input  logic [31:0]     dmdinM,
    input  logic [31:0]     pcbranchM,
    input  logic [4:0]      rtdM,

    mem_stage_if.master     dm,

    output logic            stallM,
    output logic            pcsrcM,
    output logic [31:0]     pcbranchF,
    output logic            dm_err,

    output logic            rfweW,
    output logic            mtorfselW,
    output logic [31:0]     aluoutW,
    output logic [31:0]     dmoutW,
    output logic [4:0]      rtdW,

    output logic [1:0]      dbgState,
    output logic [CNTW-1:0] dbgWaitCnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    // The counter holds the number of WAIT cycles already spent without
    // dm_ack. A WAIT cycle that sees the counter at TIMEOUT-1 is therefore
    // the TIMEOUT-th unanswered one and ends the access in ERR. On entry to
    // ERR the counter parks at TIMEOUT, which always fits in CNTW bits, so
    // it never wraps.
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t          state;
    state_t          stateNext;
    logic [CNTW-1:0] waitCnt;
    logic [CNTW-1:0] waitCntNext;

    logic            memop;
    logic            isLoad;
    logic            reqInt;
    logic            stallInt;

    // A set dmweM wins over mtorfselM: an instruction with both bits is a
    // store as far as the memory is concerned.
    assign memop  = mtorfselM | dmweM;
    assign isLoad = mtorfselM & ~dmweM;

    // -----------------------------------------------------------------------
    // FSM state register and wait counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        reqInt      = 1'b0;
        stallInt    = 1'b0;

        unique case (state)
            IDLE: begin
                // Request goes out in the very cycle the access is
                // presented, so a memory that answers at once costs no
                // stall at all.
                if (memop) begin
                    reqInt = 1'b1;
                    if (!dm.dm_ack) begin
                        stallInt    = 1'b1;
                        stateNext   = WAIT;
                        waitCntNext = '0;
                    end
                end
            end

            WAIT: begin
                // The M inputs are frozen by our own stall, so the request
                // stays valid without checking memop again.
                reqInt = 1'b1;
                if (dm.dm_ack) begin
                    stateNext = IDLE;
                end else begin
                    stallInt = 1'b1;
                    if (waitCnt == CNT_LAST) begin
                        stateNext   = ERR;
                        waitCntNext = CNT_SAT;
                    end else begin
                        waitCntNext = waitCnt + CNT_ONE;
                    end
                end
            end

            ERR: begin
                // Terminal until reset; the pipeline is held frozen and the
                // memory is no longer asked for anything.
                stallInt = 1'b1;
            end

            default: begin
                stateNext   = IDLE;
                waitCntNext = '0;
            end
        endcase

        // While reset is asserted nothing is requested and nothing is held.
        if (rst) begin
            reqInt   = 1'b0;
            stallInt = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Memory bus, control and branch outputs
    // -----------------------------------------------------------------------
    assign dm.dm_req   = reqInt;
    assign dm.dm_we    = dmweM;
    assign dm.dm_addr  = aluoutM;
    assign dm.dm_wdata = dmdinM;

    assign stallM     = stallInt;
    assign dm_err     = (state == ERR);
    assign pcsrcM     = ~rst & (state != ERR) & branchM & zeroM;
    assign pcbranchF  = pcbranchM;

    assign dbgState   = state;
    assign dbgWaitCnt = waitCnt;

    // -----------------------------------------------------------------------
    // M/W pipeline register
    // -----------------------------------------------------------------------
    // With stallM low and a memory op present, the access has necessarily
    // just been acknowledged, so dm_rdata is valid whenever a load advances.
    // A stalled cycle inserts a bubble by clearing the two control bits;
    // the data fields keep their values so nothing downstream sees garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            rfweW     <= 1'b0;
            mtorfselW <= 1'b0;
            aluoutW   <= '0;
            dmoutW    <= '0;
            rtdW      <= '0;
        end else if (!stallInt) begin
            rfweW     <= rfweM;
            mtorfselW <= mtorfselM;
            aluoutW   <= aluoutM;
            rtdW      <= rtdM;
            if (isLoad) begin
                dmoutW <= dm.dm_rdata;
            end
        end else begin
            rfweW     <= 1'b0;
            mtorfselW <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage (TIMEOUT=4).
//
// Each instruction is described by its fields and the number of cycles the
// memory takes to answer. The driver pushes the W-register contents that
// instruction must leave behind into exp_q, holds the instruction for the
// cycles it needs and checks the per-cycle handshake. The monitor pops exp_q
// each time the W register takes a new instruction and compares.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    localparam int TO = 4;
    localparam int EW = 71;   // {rfwe, mtorfsel, aluout[32], rtd[5], dmout[32]}

    // -----------------------------------------------------------------------
    // Clock and reset
    // -----------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=time limit reached required=bench finished");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // DUT
    // -----------------------------------------------------------------------
    logic        rfweM = 0, mtorfselM = 0, dmweM = 0, branchM = 0, zeroM = 0;
    logic [31:0] aluoutM = 0, dmdinM = 0, pcbranchM = 0;
    logic [4:0]  rtdM = 0;
    logic        stallM, pcsrcM, dm_err, rfweW, mtorfselW;
    logic [31:0] pcbranchF, aluoutW, dmoutW;
    logic [4:0]  rtdW;
    logic [1:0]  dbgState;
    logic [7:0]  dbgWaitCnt;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TO), .CNTW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rfweM      (rfweM),
        .mtorfselM  (mtorfselM),
        .dmweM      (dmweM),
        .branchM    (branchM),
        .zeroM      (zeroM),
        .aluoutM    (aluoutM),
        .dmdinM     (dmdinM),
        .pcbranchM  (pcbranchM),
        .rtdM       (rtdM),
        .dm         (bus),
        .stallM     (stallM),
        .pcsrcM     (pcsrcM),
        .pcbranchF  (pcbranchF),
        .dm_err     (dm_err),
        .rfweW      (rfweW),
        .mtorfselW  (mtorfselW),
        .aluoutW    (aluoutW),
        .dmoutW     (dmoutW),
        .rtdW       (rtdW),
        .dbgState   (dbgState),
        .dbgWaitCnt (dbgWaitCnt)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state and reference model
    // -----------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] monExp;
    logic [31:0]   lastLoad = 0;   // architectural value of dmoutW
    logic          retirePending = 0;
    logic          prevStall = 0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor: a cycle with stallM=0 outside reset moves one instruction
    // into W; the following negedge shows the result.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (retirePending) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL w_retire: actual=retire with empty queue required=no retire");
            end else begin
                monExp = exp_q.pop_front();
                check("w_regs", {rfweW, mtorfselW, aluoutW, rtdW, dmoutW}, monExp);
            end
        end
        if (prevStall) begin
            check("w_bubble", EW'({rfweW, mtorfselW}), '0);
        end
        retirePending = !rst && !stallM;
        prevStall     = !rst && stallM;
    end

    // -----------------------------------------------------------------------
    // Driver tasks: all start and end at posedge+1
    // -----------------------------------------------------------------------
    task automatic drive_m(input logic rfwe, mtorfsel, dmwe, branch, zero,
                           input logic [31:0] alu, din, pcb, input logic [4:0] rtd);
        rfweM = rfwe; mtorfselM = mtorfsel; dmweM = dmwe;
        branchM = branch; zeroM = zero;
        aluoutM = alu; dmdinM = din; pcbranchM = pcb; rtdM = rtd;
    endtask

    task automatic do_reset();
        if (exp_q.size() != 0) begin
            // let an instruction that retired on the last edge be popped
            @(negedge clk);
            @(posedge clk); #1;
        end
        check("q_empty_before_reset", EW'(exp_q.size()), '0);
        rst = 1'b1;
        drive_m(1, 1, 0, 1, 1, $urandom(), $urandom(), $urandom(), 5'($urandom()));
        bus.dm_ack = 1'b0;
        bus.dm_rdata = $urandom();
        @(negedge clk);
        check("rst_dm_req", EW'(bus.dm_req), '0);
        check("rst_stallM", EW'(stallM), '0);
        check("rst_pcsrcM", EW'(pcsrcM), '0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_w_regs", {rfweW, mtorfselW, aluoutW, rtdW, dmoutW}, '0);
        check("rst_dm_err", EW'(dm_err), '0);
        check("rst_state_idle", EW'(dbgState), '0);
        check("rst_stallM_2", EW'(stallM), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lastLoad = '0;
    endtask

    // One instruction. waits = cycles the memory lets pass before dm_ack.
    // strayAck raises dm_ack during a non-memory instruction.
    task automatic run_instr(input logic rfwe, mtorfsel, dmwe, branch, zero,
                             input logic [31:0] alu, din, pcb, input logic [4:0] rtd,
                             input int waits, input logic [31:0] rdata, input logic strayAck);
        logic memop;
        logic isLoad;
        int   cycles;
        memop  = mtorfsel | dmwe;
        isLoad = mtorfsel & ~dmwe;
        if (isLoad) lastLoad = rdata;
        exp_q.push_back({rfwe, mtorfsel, alu, rtd, lastLoad});
        cycles = memop ? waits + 1 : 1;
        drive_m(rfwe, mtorfsel, dmwe, branch, zero, alu, din, pcb, rtd);
        for (int c = 0; c < cycles; c++) begin
            if (memop) begin
                bus.dm_ack   = (c == waits);
                bus.dm_rdata = (c == waits) ? rdata : $urandom();
            end else begin
                bus.dm_ack   = strayAck;
                bus.dm_rdata = $urandom();
            end
            @(negedge clk);
            check("dm_req", EW'(bus.dm_req), EW'(memop));
            check("stallM", EW'(stallM), EW'(memop && (c < waits)));
            check("pcsrcM", EW'(pcsrcM), EW'(branch & zero));
            check("pcbranchF", EW'(pcbranchF), EW'(pcb));
            if (memop) begin
                check("dm_we", EW'(bus.dm_we), EW'(dmwe));
                check("dm_addr", EW'(bus.dm_addr), EW'(alu));
                check("dm_wdata", EW'(bus.dm_wdata), EW'(din));
            end
            @(posedge clk); #1;
        end
        bus.dm_ack = 1'b0;
    endtask

    task automatic run_random(input int n);
        int kind;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 3);
            run_instr(1'($urandom()), (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                      1'($urandom()), 1'($urandom()),
                      $urandom(), $urandom(), $urandom(), 5'($urandom()),
                      $urandom_range(0, TO), $urandom(), 1'($urandom()));
        end
    endtask

    // Load never answered: 1 IDLE cycle + TO WAIT cycles, then ERR.
    task automatic run_timeout();
        drive_m(1, 1, 0, 1, 1, $urandom(), $urandom(), 32'h80, 5'd3);
        for (int c = 0; c <= TO + 2; c++) begin
            bus.dm_ack   = (c > TO);   // an ack in ERR must be ignored
            bus.dm_rdata = $urandom();
            @(negedge clk);
            if (c <= TO) begin
                check("to_dm_err_low", EW'(dm_err), '0);
                check("to_dm_req_high", EW'(bus.dm_req), EW'(1'b1));
                check("to_stall_wait", EW'(stallM), EW'(1'b1));
                check("to_pcsrc_wait", EW'(pcsrcM), EW'(1'b1));
            end else begin
                check("to_dm_err_high", EW'(dm_err), EW'(1'b1));
                check("to_dm_req_low", EW'(bus.dm_req), '0);
                check("to_stall_err", EW'(stallM), EW'(1'b1));
                check("to_pcsrc_err", EW'(pcsrcM), '0);
            end
            @(posedge clk); #1;
        end
        bus.dm_ack = 1'b0;
        do_reset();
    endtask

    // Load abandoned by reset on its 2nd WAIT cycle, then a late dm_ack
    // arrives with no memory op present.
    task automatic run_reset_mid_wait();
        drive_m(1, 1, 0, 0, 0, $urandom(), $urandom(), $urandom(), 5'd9);
        bus.dm_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus.dm_rdata = $urandom();
            @(negedge clk);
            check("mw_stall", EW'(stallM), EW'(1'b1));
            check("mw_dm_req", EW'(bus.dm_req), EW'(1'b1));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mw_rst_dm_req", EW'(bus.dm_req), '0);
        check("mw_rst_stall", EW'(stallM), '0);
        check("mw_rst_pcsrc", EW'(pcsrcM), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive_m(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = $urandom() | 32'h1;
        lastLoad = '0;
        exp_q.push_back('0);
        @(negedge clk);
        check("mw_late_ack_req", EW'(bus.dm_req), '0);
        check("mw_late_ack_stall", EW'(stallM), '0);
        check("mw_state_idle", EW'(dbgState), '0);
        @(posedge clk); #1;
        bus.dm_ack = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        bus.dm_ack   = 1'b0;
        bus.dm_rdata = '0;
        do_reset();

        // zero-wait load
        run_instr(1, 1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 5'd4, 0, 32'hDEADBEEF, 0);
        // three-wait store
        run_instr(0, 0, 1, 0, 0, 32'h200, 32'h55, 32'h0, 5'd0, 3, 32'h12345678, 0);
        // branch taken / not taken
        run_instr(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h40, 5'd0, 0, 32'h0, 0);
        run_instr(0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h40, 5'd0, 0, 32'h0, 0);
        // both bits set: store, dmoutW must keep the earlier load data
        run_instr(1, 1, 1, 0, 0, 32'h300, 32'hAA, 32'h0, 5'd7, 2, 32'hCAFEF00D, 0);
        // stray ack with no access outstanding
        run_instr(1, 0, 0, 0, 0, 32'h44, 32'h0, 32'h0, 5'd8, 0, 32'h0, 1);
        // slowest answer that still completes
        run_instr(1, 1, 0, 0, 0, 32'h104, 32'h0, 32'h0, 5'd5, TO, 32'h0BADF00D, 0);

        run_random(200);
        run_timeout();
        run_random(40);
        run_reset_mid_wait();
        run_random(40);

        @(negedge clk);
        #1;
        check("q_drained", EW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
